// File: rtl/wave_capture_if.sv
// wave_capture_if: sample stream, display handshake and sample-RAM write port of the capture stage
//   new_sample_ready / new_sample_in : signed 16-bit sample strobe from the audio path
//   wave_display_idle                : display is outside its drawing region, buffer swap is safe
//   write_enable / write_address / write_sample : registered RAM write port (9-bit address, 8-bit data)
//   read_index                       : RAM half the display reads
//   capture_state                    : 0 ARMED, 1 ACTIVE, 2 WAIT (debug)
// master = capture stage, slave = surrounding system (audio source, display, RAM)
interface wave_capture_if;
   logic        new_sample_ready;
   logic [15:0] new_sample_in;
   logic        wave_display_idle;
   logic        write_enable;
   logic [8:0]  write_address;
   logic [7:0]  write_sample;
   logic        read_index;
   logic [1:0]  capture_state;
   modport master (
      input  new_sample_ready, new_sample_in, wave_display_idle,
      output write_enable, write_address, write_sample, read_index, capture_state
   );
   modport slave (
      output new_sample_ready, new_sample_in, wave_display_idle,
      input  write_enable, write_address, write_sample, read_index, capture_state
   );
endinterface

// File: rtl/wave_capture.sv
// wave_capture: triggered 256-sample capture into the off-screen half of a double-buffered sample RAM
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : wave_capture_if.master (sample strobe in, display idle in, RAM write port and status out)
// Parameters: DECIM stores every DECIM-th strobe while capturing (1..255);
//             TRIG_TIMEOUT forces a trigger after that many untriggered strobes (0 disables).
module wave_capture #(
   parameter int unsigned DECIM        = 1,
   parameter logic [15:0] TRIG_TIMEOUT = 16'd1024
) (
   input  logic            clk,
   input  logic            reset,
   wave_capture_if.master  bus
);
   typedef enum logic [1:0] {ARMED = 2'd0, ACTIVE = 2'd1, WAIT = 2'd2} state_t;
   localparam logic [7:0] DLAST = 8'(DECIM - 1);
   state_t      state;
   logic [15:0] prev_sample, tcnt;
   logic [7:0]  idx, dcnt;
   logic        read_index;
   logic        crossing, timeout;
   logic [7:0]  screen;
   assign crossing = prev_sample[15] & ~bus.new_sample_in[15];
   assign timeout  = (TRIG_TIMEOUT != 16'd0) && (tcnt + 16'd1 == TRIG_TIMEOUT);
   // flips the sign-offset so the most positive sample lands at the top row (0x00)
   assign screen   = {bus.new_sample_in[15], ~bus.new_sample_in[14:8]};
   assign bus.read_index    = read_index;
   assign bus.capture_state = state;
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= ARMED;
         prev_sample       <= 16'd0;
         tcnt              <= 16'd0;
         idx               <= 8'd0;
         dcnt              <= 8'd0;
         read_index        <= 1'b0;
         bus.write_enable  <= 1'b0;
         bus.write_address <= 9'd0;
         bus.write_sample  <= 8'd0;
      end else begin
         bus.write_enable <= 1'b0;
         if (bus.new_sample_ready) prev_sample <= bus.new_sample_in;
         case (state)
            ARMED: if (bus.new_sample_ready) begin
               if (crossing || timeout) begin
                  bus.write_enable  <= 1'b1;
                  bus.write_address <= {~read_index, 8'd0};
                  bus.write_sample  <= screen;
                  idx               <= 8'd1;
                  dcnt              <= 8'd0;
                  tcnt              <= 16'd0;
                  state             <= ACTIVE;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
            end
            ACTIVE: if (bus.new_sample_ready) begin
               if (dcnt == DLAST) begin
                  bus.write_enable  <= 1'b1;
                  bus.write_address <= {~read_index, idx};
                  bus.write_sample  <= screen;
                  dcnt              <= 8'd0;
                  idx               <= idx + 8'd1;
                  if (idx == 8'hFF) state <= WAIT;
               end else begin
                  dcnt <= dcnt + 8'd1;
               end
            end
            WAIT: if (bus.wave_display_idle) begin
               read_index <= ~read_index;
               tcnt       <= 16'd0;
               state      <= ARMED;
            end
            default: state <= ARMED;
         endcase
      end
   end
endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: three parameterisations of wave_capture driven in lockstep and checked against a strobe-counting reference model
module tb_wave_capture;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rdy = 1'b0;
   logic [15:0] smp = 16'd0;
   logic        idle = 1'b0;
   int          total = 0;
   int          bad = 0;
   always #5 clk = ~clk;
   wave_capture_if bus0 ();
   wave_capture_if bus1 ();
   wave_capture_if bus2 ();
   assign bus0.new_sample_ready = rdy;
   assign bus0.new_sample_in = smp;
   assign bus0.wave_display_idle = idle;
   assign bus1.new_sample_ready = rdy;
   assign bus1.new_sample_in = smp;
   assign bus1.wave_display_idle = idle;
   assign bus2.new_sample_ready = rdy;
   assign bus2.new_sample_in = smp;
   assign bus2.wave_display_idle = idle;
   wave_capture #(.DECIM(1), .TRIG_TIMEOUT(16'd1024)) u0 (.clk(clk), .reset(reset), .bus(bus0));
   wave_capture #(.DECIM(1), .TRIG_TIMEOUT(16'd8))    u1 (.clk(clk), .reset(reset), .bus(bus1));
   wave_capture #(.DECIM(4), .TRIG_TIMEOUT(16'd0))    u2 (.clk(clk), .reset(reset), .bus(bus2));
   // observed outputs packed as {we, addr[8:0], sample[7:0], read_index, state[1:0]}
   logic [20:0] o [3];
   assign o[0] = {bus0.write_enable, bus0.write_address, bus0.write_sample, bus0.read_index, bus0.capture_state};
   assign o[1] = {bus1.write_enable, bus1.write_address, bus1.write_sample, bus1.read_index, bus1.capture_state};
   assign o[2] = {bus2.write_enable, bus2.write_address, bus2.write_sample, bus2.read_index, bus2.capture_state};
   int dec [3] = '{1, 1, 4};
   int tmo [3] = '{1024, 8, 0};
   int          m_st [3];
   int          m_tc [3];
   int          m_n [3];
   logic [15:0] m_prev [3];
   int          m_ri [3];
   int          m_we [3];
   int          m_wa [3];
   int          m_ws [3];
   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask
   // screen row = (32767 - sample) / 256, i.e. top of screen for the most positive sample
   function automatic int screen(input logic [15:0] v);
      return (32767 - int'($signed(v))) >>> 8;
   endfunction
   task automatic emit(input int i, input int k, input logic [15:0] s);
      m_we[i] = 1;
      m_wa[i] = (m_ri[i] != 0 ? 0 : 256) + k;
      m_ws[i] = screen(s);
   endtask
   task automatic model_step(input bit r, input bit v, input logic [15:0] s, input bit idl);
      for (int i = 0; i < 3; i++) begin
         if (r) begin
            m_st[i] = 0; m_tc[i] = 0; m_n[i] = 0; m_prev[i] = 16'd0;
            m_ri[i] = 0; m_we[i] = 0; m_wa[i] = 0; m_ws[i] = 0;
         end else begin
            logic [15:0] p;
            p = m_prev[i];
            m_we[i] = 0;
            if (v) m_prev[i] = s;
            if (m_st[i] == 0 && v) begin
               if ((p[15] && !s[15]) || (tmo[i] != 0 && m_tc[i] + 1 == tmo[i])) begin
                  emit(i, 0, s);
                  m_n[i] = 0; m_tc[i] = 0; m_st[i] = 1;
               end else begin
                  m_tc[i] = (m_tc[i] + 1) % 65536;
               end
            end else if (m_st[i] == 1 && v) begin
               m_n[i]++;
               if (m_n[i] % dec[i] == 0) begin
                  emit(i, m_n[i] / dec[i], s);
                  if (m_n[i] / dec[i] == 255) m_st[i] = 2;
               end
            end else if (m_st[i] == 2 && idl) begin
               m_ri[i] ^= 1; m_tc[i] = 0; m_st[i] = 0;
            end
         end
      end
   endtask
   task automatic cyc(input bit r, input bit v, input logic [15:0] s, input bit idl);
      reset = r; rdy = v; smp = s; idle = idl;
      @(posedge clk);
      model_step(r, v, s, idl);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("u%0d_we", i), int'(o[i][20]), m_we[i]);
         check($sformatf("u%0d_addr", i), int'(o[i][19:11]), m_wa[i]);
         check($sformatf("u%0d_sample", i), int'(o[i][10:3]), m_ws[i]);
         check($sformatf("u%0d_ridx", i), int'(o[i][2]), m_ri[i]);
         check($sformatf("u%0d_state", i), int'(o[i][1:0]), m_st[i]);
      end
   endtask
   initial begin
      int wcount;
      cyc(1, 0, 16'd0, 0);
      cyc(1, 0, 16'd0, 0);
      check("reset_all", int'(o[0]), 0);
      cyc(0, 1, 16'h0100, 0);
      check("no_trig_first", int'(o[0][20]), 0);
      cyc(0, 1, 16'hFF00, 0);
      cyc(0, 1, 16'h0200, 0);
      check("trig_we", int'(o[0][20]), 1);
      check("trig_addr", int'(o[0][19:11]), 'h100);
      check("trig_sample", int'(o[0][10:3]), 'h7D);
      check("trig_state", int'(o[0][1:0]), 1);
      cyc(0, 0, 16'h0000, 0);
      check("we_one_cycle", int'(o[0][20]), 0);
      for (int k = 0; k < 255; k++) cyc(0, 1, 16'h0000, 0);
      check("last_addr", int'(o[0][19:11]), 'h1FF);
      check("last_sample", int'(o[0][10:3]), 'h7F);
      check("wait_state", int'(o[0][1:0]), 2);
      for (int k = 0; k < 10; k++) begin
         cyc(0, 1, 16'h8000 + 16'(k), 0);
         cyc(0, 1, 16'h0001, 0);
         check("wait_no_write", int'(o[0][20]), 0);
      end
      for (int k = 0; k < 50; k++) cyc(0, 0, 16'h0000, 0);
      check("hold_ridx", int'(o[0][2]), 0);
      cyc(0, 1, 16'h0000, 1);
      check("swap_ridx", int'(o[0][2]), 1);
      check("swap_state", int'(o[0][1:0]), 0);
      check("swap_no_trig", int'(o[0][20]), 0);
      cyc(0, 1, 16'hFFFF, 0);
      cyc(0, 1, 16'h0001, 0);
      check("half0_we", int'(o[0][20]), 1);
      check("half0_addr", int'(o[0][19:11]), 'h000);
      cyc(1, 0, 16'd0, 0);
      for (int k = 1; k <= 8; k++) begin
         cyc(0, 1, 16'h1000, 0);
         if (k == 7) check("tmo_early", int'(o[1][20]), 0);
      end
      check("tmo_we", int'(o[1][20]), 1);
      check("tmo_sample", int'(o[1][10:3]), 'h6F);
      check("tmo_addr", int'(o[1][19:11]), 'h100);
      check("tmo_off_u2", int'(o[2][20]), 0);
      cyc(1, 0, 16'd0, 0);
      cyc(0, 1, 16'h8000, 0);
      cyc(0, 1, 16'h0005, 0);
      for (int k = 0; k < 99; k++) cyc(0, 1, 16'h0000, 0);
      check("mid_addr", int'(o[0][19:11]), 'h163);
      cyc(1, 1, 16'h0000, 0);
      check("mid_reset", int'(o[0]), 0);
      cyc(0, 1, 16'h8000, 0);
      cyc(0, 1, 16'h0005, 0);
      check("restart_addr", int'(o[0][19:11]), 'h100);
      check("restart_sample", int'(o[0][10:3]), 'h7F);
      cyc(1, 0, 16'd0, 0);
      cyc(0, 1, 16'hFFFF, 0);
      cyc(0, 1, 16'h0001, 0);
      check("dec_trig", int'(o[2][20]), 1);
      wcount = 0;
      for (int k = 1; k <= 1020; k++) begin
         cyc(0, 1, 16'($urandom), 0);
         wcount += int'(o[2][20]);
         if (k == 1019) check("dec_not_done", int'(o[2][1:0]), 1);
      end
      check("dec_writes", wcount, 255);
      check("dec_last_addr", int'(o[2][19:11]), 'h1FF);
      check("dec_state", int'(o[2][1:0]), 2);
      for (int k = 0; k < 4000; k++)
         cyc($urandom_range(0, 999) == 0, $urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
